// File: rtl/rr_write_arbiter.sv
// -----------------------------------------------------------------------------
// rr_write_arbiter
//
// Four-requester round-robin arbiter for the register-file write port. It
// grants one source at a time with a registered one-hot grant (same form as
// the 2-to-4 write-select decode) and the matching encoded owner index. It
// also bounds how long an owner may hold the port while another source waits.
//
// Handshake: req[i] is a level request that the source holds high for as long
// as it wants the port. grant[i] is the registered answer. A source owns the
// port in every cycle where grant[i]=1. After the owner drops req[i], it
// still sees its grant for one more cycle, and must tolerate that overlap.
// Requests from non-owners are not latched. A source that drops req before it
// is granted is simply forgotten.
//
// Parameters:
//   HOLD_MAX   maximum consecutive grant cycles for one owner under
//              contention (legal 2..255)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        request per source, bit i = source i
//   grant      registered one-hot grant, 4'b0000 when idle
//   grant_idx  encoded owner, meaningful only while busy=1
//   busy       high while any grant bit is high (mirrors FSM state BUSY)
//   timeout    one-cycle pulse in the first cycle of a preempting owner
// -----------------------------------------------------------------------------
module rr_write_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  // The counter only has to reach HOLD_MAX-1, so clog2(HOLD_MAX) bits suffice.
  localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [1:0]    idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] hold_q, hold_d;

  logic [1:0]    owner;
  logic [3:0]    others;
  logic [2:0]    pick_idle;
  logic [2:0]    pick_next;

  // Round-robin search: the first set bit of mask, scanning start, start+1,
  // start+2, start+3 with 2-bit wrap. Result is {found, index}. The loop runs
  // from the farthest candidate down so that the nearest one is written last
  // and wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] start);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = start;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign owner  = idx_q;
  // This mask excludes the owner. On release req[owner] is already 0, so one
  // search from owner+1 over this mask serves both release and preempt.
  assign others = req & ~onehot(owner);

  assign pick_idle = rr_pick(req, last_q + 2'd1);
  assign pick_next = rr_pick(others, owner + 2'd1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_idle[2]) begin
          grant_d = onehot(pick_idle[1:0]);
          idx_d   = pick_idle[1:0];
          busy_d  = 1'b1;
          hold_d  = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (!req[owner]) begin
          // Release. A request that arrives on this same edge takes part
          // in the search, so handover has no dead cycle.
          last_d = owner;
          hold_d = '0;
          if (pick_next[2]) begin
            grant_d = onehot(pick_next[1:0]);
            idx_d   = pick_next[1:0];
          end else begin
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (hold_q == HOLD_LAST) begin
          // Hold limit reached. Preempt only if someone else is waiting.
          // Otherwise the counter stays saturated, so preemption fires on
          // the first cycle that contention appears.
          if (pick_next[2]) begin
            last_d    = owner;
            grant_d   = onehot(pick_next[1:0]);
            idx_d     = pick_next[1:0];
            hold_d    = '0;
            timeout_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 4'b0000;
      idx_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= 2'd3;   // source 0 gets first priority after reset
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_write_arbiter
//
// Directed bench for rr_write_arbiter with HOLD_MAX=4. Each scenario task
// drives req. It compares {grant, grant_idx, busy, timeout} against values
// worked out by hand. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_rr_write_arbiter;

  localparam int unsigned HM = 4;
  localparam logic [3:0] RR_SEQ [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  int pass_cnt;
  int total_cnt;

  rr_write_arbiter #(.HOLD_MAX(HM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({grant, grant_idx, busy, timeout} !== 8'b0000_00_0_0) begin
      $display("FAIL reset_outputs: got %b expected %b",
               {grant, grant_idx, busy, timeout}, 8'b0000_00_0_0);
    end else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({grant, busy, timeout} !== 6'b0000_0_0) begin
      $display("FAIL idle_no_req: got %b expected %b", {grant, busy, timeout}, 6'b0000_0_0);
    end else pass_cnt++;
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100;
    tick();
    total_cnt++;
    if ({grant, grant_idx, busy, timeout} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      $display("FAIL single_grant: got %b expected %b",
               {grant, grant_idx, busy, timeout}, {4'b0100, 2'd2, 1'b1, 1'b0});
    end else pass_cnt++;
    req = 4'b0000;
    tick();
    total_cnt++;
    if ({grant, busy, timeout} !== 6'b0000_0_0) begin
      $display("FAIL single_release: got %b expected %b", {grant, busy, timeout}, 6'b0000_0_0);
    end else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    req = 4'b1111;
    tick();
    for (int s = 0; s < 5; s++) begin
      total_cnt++;
      if ({grant, grant_idx, busy, timeout} !== {RR_SEQ[s], 2'(s % 4), 1'b1, 1'b0}) begin
        $display("FAIL rr_order step %0d: got %b expected %b", s,
                 {grant, grant_idx, busy, timeout}, {RR_SEQ[s], 2'(s % 4), 1'b1, 1'b0});
      end else pass_cnt++;
      if (s < 4) begin
        tick();
        total_cnt++;
        if ({grant, busy} !== {RR_SEQ[s], 1'b1}) begin
          $display("FAIL rr_hold step %0d: got %b expected %b", s,
                   {grant, busy}, {RR_SEQ[s], 1'b1});
        end else pass_cnt++;
        req = 4'b1111 & ~RR_SEQ[s];
        tick();
        req = 4'b1111;
      end
    end
  endtask

  task automatic test_preempt();
    apply_reset();
    req = 4'b0011;
    tick();
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if ({grant, timeout} !== {4'b0001, 1'b0}) begin
        $display("FAIL preempt_hold0 cycle %0d: got %b expected %b", c,
                 {grant, timeout}, {4'b0001, 1'b0});
      end else pass_cnt++;
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if ({grant, grant_idx, timeout} !== {4'b0010, 2'd1, (c == 0)}) begin
        $display("FAIL preempt_hold1 cycle %0d: got %b expected %b", c,
                 {grant, grant_idx, timeout}, {4'b0010, 2'd1, (c == 0)});
      end else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({grant, grant_idx, timeout} !== {4'b0001, 2'd0, 1'b1}) begin
      $display("FAIL preempt_return: got %b expected %b",
               {grant, grant_idx, timeout}, {4'b0001, 2'd0, 1'b1});
    end else pass_cnt++;
  endtask

  task automatic test_saturate();
    apply_reset();
    req = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      tick();
      total_cnt++;
      if ({grant, busy, timeout} !== {4'b1000, 1'b1, 1'b0}) begin
        $display("FAIL sole_hold cycle %0d: got %b expected %b", c,
                 {grant, busy, timeout}, {4'b1000, 1'b1, 1'b0});
      end else pass_cnt++;
    end
    req = 4'b1010;
    tick();
    total_cnt++;
    if ({grant, grant_idx, timeout} !== {4'b0010, 2'd1, 1'b1}) begin
      $display("FAIL sole_preempt: got %b expected %b",
               {grant, grant_idx, timeout}, {4'b0010, 2'd1, 1'b1});
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({grant, timeout} !== {4'b0010, 1'b0}) begin
      $display("FAIL timeout_pulse_width: got %b expected %b", {grant, timeout}, {4'b0010, 1'b0});
    end else pass_cnt++;
  endtask

  task automatic test_wrap();
    apply_reset();
    req = 4'b1000;
    tick();
    // owner 3 drops in the same cycle that sources 0 and 2 request
    req = 4'b0101;
    tick();
    total_cnt++;
    if ({grant, grant_idx, busy, timeout} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
      $display("FAIL wrap_3_to_0: got %b expected %b",
               {grant, grant_idx, busy, timeout}, {4'b0001, 2'd0, 1'b1, 1'b0});
    end else pass_cnt++;
    req = 4'b0100;
    tick();
    total_cnt++;
    if ({grant, grant_idx, busy, timeout} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      $display("FAIL wrap_0_to_2: got %b expected %b",
               {grant, grant_idx, busy, timeout}, {4'b0100, 2'd2, 1'b1, 1'b0});
    end else pass_cnt++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b0100;
    tick();
    tick();
    tick();          // owner 2 now has hold_cnt=2
    req = 4'b1100;
    #2;
    rst_n = 1'b0;    // between edges
    #1;
    total_cnt++;
    if ({grant, grant_idx, busy, timeout} !== 8'b0000_00_0_0) begin
      $display("FAIL async_reset: got %b expected %b",
               {grant, grant_idx, busy, timeout}, 8'b0000_00_0_0);
    end else pass_cnt++;
    #2;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({grant, grant_idx, busy, timeout} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      $display("FAIL post_reset_grant: got %b expected %b",
               {grant, grant_idx, busy, timeout}, {4'b0100, 2'd2, 1'b1, 1'b0});
    end else pass_cnt++;
    // A cleared hold counter gives owner 2 a full HOLD_MAX cycles.
    for (int c = 0; c < 3; c++) begin
      tick();
      total_cnt++;
      if ({grant, timeout} !== {4'b0100, 1'b0}) begin
        $display("FAIL post_reset_hold cycle %0d: got %b expected %b", c,
                 {grant, timeout}, {4'b0100, 1'b0});
      end else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({grant, grant_idx, timeout} !== {4'b1000, 2'd3, 1'b1}) begin
      $display("FAIL post_reset_preempt: got %b expected %b",
               {grant, grant_idx, timeout}, {4'b1000, 2'd3, 1'b1});
    end else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    req       = 4'b0000;
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_saturate();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
